// File: rtl/mat_mul_ctrl_if.sv
// rtl/mat_mul_ctrl_if.sv - job/row handshake and ALU/RAM control bundle for mat_mul_ctrl
interface mat_mul_ctrl_if;
    logic       start;
    logic [1:0] cfg_bank;
    logic       in_valid;
    logic       in_ready;
    logic       x_load;
    logic [1:0] x_load_sel;
    logic [3:0] rom_addr;
    logic [2:0] count_mul;
    logic       acc_en;
    logic       acc_first;
    logic       x_shift;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [1:0] ram_sel;
    logic       busy;
    logic       done;

    modport master (
        output start, cfg_bank, in_valid,
        input  in_ready, x_load, x_load_sel, rom_addr, count_mul, acc_en, acc_first,
               x_shift, ram_we, ram_addr, ram_sel, busy, done
    );

    modport slave (
        input  start, cfg_bank, in_valid,
        output in_ready, x_load, x_load_sel, rom_addr, count_mul, acc_en, acc_first,
               x_shift, ram_we, ram_addr, ram_sel, busy, done
    );
endinterface

// File: rtl/mat_mul_ctrl.sv
// rtl/mat_mul_ctrl.sv - sequencer for the four-lane matrix-multiply ALU
module mat_mul_ctrl #(
    parameter int ROM_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    mat_mul_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic DRAIN_LAST = (ROM_LAT == 2) ? 1'b1 : 1'b0;

    state_t     st, st_n;
    logic [1:0] bank, bank_n;
    logic [1:0] row, row_n;
    logic [2:0] j, j_n;
    logic [1:0] k, k_n;
    logic [1:0] i, i_n;
    logic       d, d_n;
    logic       mac_d, first_d;

    // The row word is only on the bus while in_valid is high, so the load strobe follows it directly.
    assign bus.x_load = bus.in_ready & bus.in_valid;

    always_comb begin
        st_n   = st;
        bank_n = bank;
        row_n  = row;
        j_n    = j;
        k_n    = k;
        i_n    = i;
        d_n    = d;
        case (st)
            IDLE: begin
                if (bus.start) begin
                    st_n   = LOAD;
                    bank_n = bus.cfg_bank;
                    row_n  = 2'd0;
                    j_n    = 3'd0;
                    k_n    = 2'd0;
                    i_n    = 2'd0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    if (row == 2'd3) begin
                        st_n = MAC;
                        k_n  = 2'd0;
                    end else begin
                        row_n = row + 2'd1;
                    end
                end
            end
            MAC: begin
                if (k == 2'd3) begin
                    st_n = DRAIN;
                    d_n  = 1'b0;
                end else begin
                    k_n = k + 2'd1;
                end
            end
            DRAIN: begin
                if (d == DRAIN_LAST) begin
                    st_n = WRITE;
                    i_n  = 2'd0;
                end else begin
                    d_n = 1'b1;
                end
            end
            WRITE: begin
                if (i == 2'd3) begin
                    if (j == 3'd7) begin
                        st_n = DONE;
                    end else begin
                        st_n = MAC;
                        j_n  = j + 3'd1;
                        k_n  = 2'd0;
                    end
                end else begin
                    i_n = i + 2'd1;
                end
            end
            DONE:    st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so each one lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= IDLE;
            bank           <= 2'd0;
            row            <= 2'd0;
            j              <= 3'd0;
            k              <= 2'd0;
            i              <= 2'd0;
            d              <= 1'b0;
            mac_d          <= 1'b0;
            first_d        <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.x_load_sel <= 2'd0;
            bus.rom_addr   <= 4'd0;
            bus.count_mul  <= 3'd0;
            bus.acc_en     <= 1'b0;
            bus.acc_first  <= 1'b0;
            bus.x_shift    <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= 5'd0;
            bus.ram_sel    <= 2'd0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            st   <= st_n;
            bank <= bank_n;
            row  <= row_n;
            j    <= j_n;
            k    <= k_n;
            i    <= i_n;
            d    <= d_n;

            // ROM data for an address issued in a MAC cycle arrives ROM_LAT cycles later.
            mac_d         <= (st == MAC);
            first_d       <= (st == MAC) && (k == 2'd0);
            bus.acc_en    <= (ROM_LAT == 2) ? mac_d   : (st == MAC);
            bus.acc_first <= (ROM_LAT == 2) ? first_d : ((st == MAC) && (k == 2'd0));

            bus.in_ready   <= (st_n == LOAD);
            bus.x_load_sel <= (st_n == LOAD) ? row_n : 2'd0;
            bus.rom_addr   <= (st_n == MAC) ? {bank_n, k_n} : 4'd0;
            bus.count_mul  <= (st_n == IDLE || st_n == LOAD) ? 3'd0 : j_n;
            bus.x_shift    <= (st_n == WRITE) && (i_n == 2'd3) && (j_n != 3'd7);
            bus.ram_we     <= (st_n == WRITE);
            bus.ram_addr   <= (st_n == WRITE) ? {j_n, i_n} : 5'd0;
            bus.ram_sel    <= (st_n == WRITE) ? i_n : 2'd0;
            bus.busy       <= (st_n != IDLE);
            bus.done       <= (st_n == DONE);
        end
    end
endmodule

// File: tb/tb_mat_mul_ctrl.sv
// tb/tb_mat_mul_ctrl.sv - scoreboard bench for mat_mul_ctrl at ROM_LAT 1 and 2
module tb_mat_mul_ctrl;
    logic clk = 1'b0;
    logic rst;

    initial forever #5 clk = ~clk;

    mat_mul_ctrl_if if1 ();
    mat_mul_ctrl_if if2 ();

    mat_mul_ctrl #(.ROM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mat_mul_ctrl #(.ROM_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct packed {
        logic       in_ready;
        logic       x_load;
        logic [1:0] x_load_sel;
        logic [3:0] rom_addr;
        logic [2:0] count_mul;
        logic       acc_en;
        logic       acc_first;
        logic       x_shift;
        logic       ram_we;
        logic [4:0] ram_addr;
        logic [1:0] ram_sel;
        logic       busy;
        logic       done;
    } snap_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nx[2], nw[2], nsh[2], last_row[2], last_k0[2];
    bit done_seen[2];
    logic [1:0] hm[2], hf[2];
    int qs0[$], qs1[$], qr0[$], qr1[$], qw0[$], qw1[$];
    bit poked;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic snap_t get_snap(input int d);
        snap_t s;
        if (d == 0) s = {if1.in_ready, if1.x_load, if1.x_load_sel, if1.rom_addr, if1.count_mul,
                         if1.acc_en, if1.acc_first, if1.x_shift, if1.ram_we, if1.ram_addr,
                         if1.ram_sel, if1.busy, if1.done};
        else        s = {if2.in_ready, if2.x_load, if2.x_load_sel, if2.rom_addr, if2.count_mul,
                         if2.acc_en, if2.acc_first, if2.x_shift, if2.ram_we, if2.ram_addr,
                         if2.ram_sel, if2.busy, if2.done};
        return s;
    endfunction

    // kind 0 = x_load_sel, 1 = rom_addr, 2 = ram_addr
    function automatic int pop(input int d, input int kind);
        int v;
        v = -1;
        if (d == 0 && kind == 0 && qs0.size() > 0) v = qs0.pop_front();
        if (d == 1 && kind == 0 && qs1.size() > 0) v = qs1.pop_front();
        if (d == 0 && kind == 1 && qr0.size() > 0) v = qr0.pop_front();
        if (d == 1 && kind == 1 && qr1.size() > 0) v = qr1.pop_front();
        if (d == 0 && kind == 2 && qw0.size() > 0) v = qw0.pop_front();
        if (d == 1 && kind == 2 && qw1.size() > 0) v = qw1.pop_front();
        return v;
    endfunction

    task automatic process(input int d, input snap_t s, input int lat);
        int   e;
        logic mac_now, first_now, exp_en, exp_first;
        mac_now   = (s.rom_addr != 4'd0);
        first_now = mac_now && (s.rom_addr[1:0] == 2'd0);
        exp_en    = (lat == 1) ? hm[d][0] : hm[d][1];
        exp_first = (lat == 1) ? hf[d][0] : hf[d][1];
        if (s.acc_en === 1'b1 || exp_en === 1'b1)
            chk($sformatf("acc_en_d%0d", d), int'(s.acc_en), int'(exp_en));
        if (s.acc_first === 1'b1 || exp_first === 1'b1)
            chk($sformatf("acc_first_d%0d", d), int'(s.acc_first), int'(exp_first));
        hm[d] = {hm[d][0], mac_now};
        hf[d] = {hf[d][0], first_now};
        if (s.x_load === 1'b1) begin
            nx[d]++;
            e = pop(d, 0);
            chk($sformatf("x_load_sel_d%0d", d), int'(s.x_load_sel), e);
            if (s.x_load_sel == 2'd3) last_row[d] = cyc;
        end
        if (mac_now === 1'b1) begin
            e = pop(d, 1);
            chk($sformatf("rom_addr_d%0d", d), int'(s.rom_addr), e);
            if (first_now) begin
                if (last_k0[d] < 0) chk($sformatf("mac_after_load_d%0d", d), cyc - last_row[d], 1);
                else                chk($sformatf("col_period_d%0d", d), cyc - last_k0[d], 8 + lat);
                last_k0[d] = cyc;
            end
        end
        if (s.ram_we === 1'b1) begin
            nw[d]++;
            e = pop(d, 2);
            chk($sformatf("ram_addr_d%0d", d), int'(s.ram_addr), e);
            chk($sformatf("ram_sel_d%0d", d), int'(s.ram_sel), e % 4);
            chk($sformatf("count_mul_d%0d", d), int'(s.count_mul), e / 4);
            chk($sformatf("we_acc_overlap_d%0d", d), int'(s.acc_en), 0);
        end
        if (s.x_shift === 1'b1) begin
            nsh[d]++;
            chk($sformatf("x_shift_slot_d%0d", d), int'({s.ram_we, s.ram_sel}), 7);
        end
        if (s.done === 1'b1) begin
            done_seen[d] = 1'b1;
            chk($sformatf("done_latency_d%0d", d), cyc - last_row[d], 8 * (8 + lat) + 1);
        end
    endtask

    // Inputs are set before tick; the cycle is sampled mid-cycle, then the edge commits it.
    task automatic tick();
        @(negedge clk);
        process(0, get_snap(0), 1);
        process(1, get_snap(1), 2);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic s, input logic [1:0] b, input logic v);
        if1.start = s; if1.cfg_bank = b; if1.in_valid = v;
        if2.start = s; if2.cfg_bank = b; if2.in_valid = v;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            hm[d] = 2'b00; hf[d] = 2'b00;
        end
        qs0.delete(); qs1.delete(); qr0.delete(); qr1.delete(); qw0.delete(); qw1.delete();
    endtask

    task automatic start_job(input logic [1:0] b);
        for (int d = 0; d < 2; d++) begin
            nx[d] = 0; nw[d] = 0; nsh[d] = 0; last_row[d] = -1; last_k0[d] = -1; done_seen[d] = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
            qs0.push_back(r); qs1.push_back(r);
        end
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 4; k++) begin
                qr0.push_back(b * 4 + k); qr1.push_back(b * 4 + k);
            end
        end
        for (int a = 0; a < 32; a++) begin
            qw0.push_back(a); qw1.push_back(a);
        end
        drive(1'b1, b, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b0);
        chk("in_ready_after_start", int'(if1.in_ready), 1);
    endtask

    task automatic feed(input logic [6:0] pat, input int n);
        for (int t = 0; t < n; t++) begin
            drive(1'b0, 2'd0, pat[t]);
            tick();
        end
        drive(1'b0, 2'd0, 1'b0);
    endtask

    task automatic wait_done(input bit poke);
        int n;
        n = 0;
        poked = 1'b0;
        while (!(done_seen[0] && done_seen[1]) && n < 300) begin
            if (poke && !poked && if1.count_mul == 3'd3) begin
                drive(1'b1, 2'd1, 1'b0);
                poked = 1'b1;
                tick();
                drive(1'b0, 2'd0, 1'b0);
            end else begin
                tick();
            end
            n++;
        end
        chk("done_timeout", int'(done_seen[0] && done_seen[1]), 1);
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ram_we_count_d%0d", d), nw[d], 32);
            chk($sformatf("x_shift_count_d%0d", d), nsh[d], 7);
            chk($sformatf("x_load_count_d%0d", d), nx[d], 4);
        end
        chk("queues_drained", qs0.size() + qs1.size() + qr0.size() + qr1.size() + qw0.size() + qw1.size(), 0);
        chk("idle_after_done", int'(if1.busy), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            nx[d] = 0; nw[d] = 0; nsh[d] = 0; last_row[d] = -1; last_k0[d] = -1; done_seen[d] = 1'b0;
        end
        tick();
        tick();
        clear_model();
        chk("reset_outputs_d0", int'(get_snap(0)), 0);
        chk("reset_outputs_d1", int'(get_snap(1)), 0);
        rst = 1'b0;

        for (int t = 0; t < 20; t++) begin
            tick();
            chk("idle_busy", int'(if1.busy), 0);
        end
        chk("idle_no_activity", nx[0] + nw[0] + nx[1] + nw[1], 0);

        // full job without stalls, with a start pulse (bank 1) during column 3
        start_job(2'd2);
        feed(7'b0001111, 4);
        wait_done(1'b1);

        // LOAD with stalls
        start_job(2'd2);
        feed(7'b1011001, 7);
        wait_done(1'b0);

        // reset while writing j=4, i=1
        start_job(2'd2);
        feed(7'b0001111, 4);
        n = 0;
        while (!(if1.ram_we === 1'b1 && if1.ram_addr == 5'd17) && n < 200) begin
            tick();
            n++;
        end
        chk("reach_write_j4_i1", n < 200 ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("mid_reset_outputs_d0", int'(get_snap(0)), 0);
        chk("mid_reset_outputs_d1", int'(get_snap(1)), 0);
        nw[0] = 0; nx[0] = 0; done_seen[0] = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        chk("mid_reset_quiet", nw[0] + nx[0] + int'(done_seen[0]), 0);

        // fresh job after the abort restarts at ram_addr 0
        start_job(2'd2);
        feed(7'b0001111, 4);
        wait_done(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
